// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared state encoding, mode constants and saturating add for audio_frame_buffer
package audio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam logic MODE_RECORD = 1'b0;
    localparam logic MODE_PLAY   = 1'b1;

    // Signed saturating add of two width-bit two's-complement values held in the LSBs.
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b, input int width);
        longint span;
        longint mx;
        longint mn;
        longint sa;
        longint sb;
        longint s;
        span = longint'(1) <<< width;
        mx   = (longint'(1) <<< (width - 1)) - longint'(1);
        mn   = -mx - longint'(1);
        sa   = longint'({32'd0, a}) & (span - longint'(1));
        sb   = longint'({32'd0, b}) & (span - longint'(1));
        if (sa > mx) sa = sa - span;
        if (sb > mx) sb = sb - span;
        s = sa + sb;
        if (s > mx) s = mx;
        if (s < mn) s = mn;
        return s[31:0];
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word-fall-through synchronous FIFO with flush and occupancy count
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is legal when the head leaves on the same edge.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full    = (cnt == FULL_CNT);
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !rst && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop) begin
                cnt <= cnt + 1'b1;
            end else if (!do_push && do_pop) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/audio_frame_buffer.sv
// rtl/audio_frame_buffer.sv - I2S frame <-> DDR burst bridge; OVERDUB_EN mixes live input into playback
module audio_frame_buffer
    import audio_pkg::*;
#(
    parameter int SAMPLE_W  = 24,
    parameter int CH_COUNT  = 2,
    parameter int MEM_W     = 64,
    parameter int DEPTH     = 16,
    parameter int BURST_LEN = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          mode,
    input  logic                          lrclk,
    input  logic [CH_COUNT*SAMPLE_W-1:0]  adc_data,
    output logic [CH_COUNT*SAMPLE_W-1:0]  dac_data,
    output logic [MEM_W-1:0]              mem_wr_data,
    output logic                          mem_wr_valid,
    input  logic                          mem_wr_ready,
    input  logic [MEM_W-1:0]              mem_rd_data,
    input  logic                          mem_rd_valid,
    output logic                          mem_rd_ready,
    output logic                          burst_req,
    output logic [$clog2(DEPTH+1)-1:0]    fill_level,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int DW = CH_COUNT * SAMPLE_W;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] BURST_CNT = CW'(BURST_LEN);
    localparam logic [CW-1:0] ROOM_CNT  = CW'(DEPTH - BURST_LEN);
    localparam logic [CW-1:0] ONE_CNT   = CW'(1);

    if (DW > MEM_W) begin : g_width_check
        $error("audio_frame_buffer: CH_COUNT*SAMPLE_W exceeds MEM_W");
    end
    if ((DEPTH & (DEPTH - 1)) != 0 || DEPTH < 2 * BURST_LEN) begin : g_depth_check
        $error("audio_frame_buffer: DEPTH must be a power of two and >= 2*BURST_LEN");
    end

    state_t          state;
    logic            mode_q;
    logic            lr_s1, lr_s2, lr_s3, strobe;
    logic            fifo_full, fifo_empty, fifo_push, fifo_pop, fifo_flush;
    logic [MEM_W-1:0] fifo_head, push_data;
    logic [CW-1:0]   fifo_count;
    logic            is_rec, pop_wr, push_rec, push_play, pop_play;
    logic [DW-1:0]   play_word, starve_word;

    always_ff @(posedge clk) begin
        if (rst) begin
            lr_s1  <= 1'b0;
            lr_s2  <= 1'b0;
            lr_s3  <= 1'b0;
            strobe <= 1'b0;
        end else begin
            lr_s1  <= lrclk;
            lr_s2  <= lr_s1;
            lr_s3  <= lr_s2;
            strobe <= lr_s2 && !lr_s3;
        end
    end

    assign is_rec       = (mode_q == MODE_RECORD);
    assign mem_wr_valid = is_rec && (state == ST_RUN || state == ST_DRAIN) && !fifo_empty;
    assign mem_wr_data  = mem_wr_valid ? fifo_head : '0;
    assign pop_wr       = mem_wr_valid && mem_wr_ready;
    assign push_rec     = is_rec && (state == ST_RUN) && strobe && (!fifo_full || pop_wr);
    assign mem_rd_ready = !is_rec && (state == ST_PRIME || state == ST_RUN) && !fifo_full;
    assign push_play    = mem_rd_ready && mem_rd_valid;
    assign pop_play     = !is_rec && (state == ST_RUN) && enable && strobe && !fifo_empty;
    assign fifo_flush   = !is_rec && (state == ST_PRIME || state == ST_RUN) && !enable;
    assign fifo_push    = push_rec || push_play;
    assign fifo_pop     = pop_wr || pop_play;
    assign push_data    = is_rec ? MEM_W'(adc_data) : mem_rd_data;
    assign fill_level   = fifo_count;

    always_comb begin
        burst_req = 1'b0;
        case (state)
            ST_PRIME: burst_req = !is_rec && (fifo_count <= ROOM_CNT);
            ST_RUN:   burst_req = is_rec ? (fifo_count >= BURST_CNT) : (fifo_count <= ROOM_CNT);
            ST_DRAIN: burst_req = is_rec && (fifo_count != '0);
            default:  burst_req = 1'b0;
        endcase
    end

`ifdef OVERDUB_EN
    logic [31:0] mix_tmp;
    always_comb begin
        play_word = '0;
        mix_tmp   = '0;
        for (int ch = 0; ch < CH_COUNT; ch++) begin
            mix_tmp = sat_add(32'(fifo_head[ch*SAMPLE_W +: SAMPLE_W]),
                              32'(adc_data[ch*SAMPLE_W +: SAMPLE_W]), SAMPLE_W);
            play_word[ch*SAMPLE_W +: SAMPLE_W] = mix_tmp[SAMPLE_W-1:0];
        end
    end
    assign starve_word = adc_data;
`else
    assign play_word   = fifo_head[DW-1:0];
    assign starve_word = '0;
`endif

    sync_fifo #(.WIDTH(MEM_W), .DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (fifo_flush),
        .push      (fifo_push),
        .push_data (push_data),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            mode_q    <= MODE_RECORD;
            dac_data  <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    dac_data <= '0;
                    if (enable) begin
                        mode_q    <= mode;
                        overflow  <= 1'b0;
                        underflow <= 1'b0;
                        state     <= (mode == MODE_PLAY) ? ST_PRIME : ST_RUN;
                    end
                end
                ST_PRIME: begin
                    dac_data <= '0;
                    if (!enable) begin
                        state <= ST_IDLE;
                    end else if (fifo_count >= BURST_CNT) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (is_rec) begin
                        if (strobe && fifo_full && !pop_wr) overflow <= 1'b1;
                        if (!enable) state <= ST_DRAIN;
                    end else if (!enable) begin
                        state    <= ST_IDLE;
                        dac_data <= '0;
                    end else if (strobe) begin
                        if (fifo_empty) begin
                            dac_data  <= starve_word;
                            underflow <= 1'b1;
                        end else begin
                            dac_data <= play_word;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Leave on the edge that removes the last word.
                    if (fifo_empty || (fifo_count == ONE_CNT && pop_wr)) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_audio_frame_buffer.sv
// tb/tb_audio_frame_buffer.sv - randomized self-checking bench for audio_frame_buffer
module tb_audio_frame_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        mode = 1'b0;
    logic        lrclk = 1'b0;
    logic [47:0] adc_data = '0;
    logic [47:0] dac_data;
    logic [63:0] mem_wr_data;
    logic        mem_wr_valid;
    logic        mem_wr_ready = 1'b0;
    logic [63:0] mem_rd_data = '0;
    logic        mem_rd_valid = 1'b0;
    logic        mem_rd_ready;
    logic        burst_req;
    logic [4:0]  fill_level;
    logic        overflow;
    logic        underflow;

    int errors = 0;
    int checks = 0;
    logic [63:0] got_q[$];
    logic [63:0] exp_q[$];
    logic [63:0] play_w[$];

    audio_frame_buffer dut (
        .clk(clk), .rst(rst), .enable(enable), .mode(mode), .lrclk(lrclk),
        .adc_data(adc_data), .dac_data(dac_data),
        .mem_wr_data(mem_wr_data), .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready),
        .mem_rd_data(mem_rd_data), .mem_rd_valid(mem_rd_valid), .mem_rd_ready(mem_rd_ready),
        .burst_req(burst_req), .fill_level(fill_level),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(negedge clk);
            if (mem_wr_valid && mem_wr_ready) got_q.push_back(mem_wr_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe_frame();
        lrclk = 1'b1;
        repeat (3) tick();
        lrclk = 1'b0;
        repeat (3) tick();
    endtask

    task automatic drain_and_compare(input string name);
        int k;
        enable = 1'b0;
        mem_wr_ready = 1'b1;
        for (k = 0; k < 60 && (mem_wr_valid || k < 2); k++) tick();
        checks++;
        if (mem_wr_valid) begin
            errors++;
            $display("FAIL %s_drain_timeout: mem_wr_valid still %b, want 0", name, mem_wr_valid);
        end
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s_count: got %0d words, want %0d", name, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL %s_word%0d: got %h want %h", name, i, got_q[i], exp_q[i]);
            end
        end
        got_q.delete();
        exp_q.delete();
        mem_wr_ready = 1'b0;
    endtask

    task automatic feed_words(input int n);
        logic r;
        int guard;
        for (int i = 0; i < n; i++) begin
            guard = 0;
            r = 1'b0;
            mem_rd_valid = 1'b1;
            mem_rd_data  = play_w[i];
            while (!r && guard < 20) begin
                @(negedge clk);
                r = mem_rd_ready;
                tick();
                guard++;
            end
            checks++;
            if (!r) begin
                errors++;
                $display("FAIL feed_timeout: word %0d not accepted, mem_rd_ready %b want 1", i, r);
            end
        end
        mem_rd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        checks++;
        if ({dac_data, mem_wr_data, mem_wr_valid, mem_rd_ready, burst_req, fill_level, overflow, underflow} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: dac %h wr %h v %b rr %b br %b fill %0d ov %b un %b, want all 0",
                     dac_data, mem_wr_data, mem_wr_valid, mem_rd_ready, burst_req, fill_level, overflow, underflow);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_record_stream();
        mode = 1'b0; enable = 1'b1; mem_wr_ready = 1'b1;
        tick();
        for (int n = 0; n < 10; n++) begin
            adc_data = {24'hA00000 + 24'(n), 24'hB00000 + 24'(n)};
            exp_q.push_back({16'h0000, adc_data});
            strobe_frame();
        end
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL stream_overflow: got %b want 0", overflow);
        end
        drain_and_compare("stream");
    endtask

    task automatic test_record_random();
        mode = 1'b0; enable = 1'b1;
        tick();
        for (int n = 0; n < 20; n++) begin
            mem_wr_ready = ($urandom_range(0, 3) != 0);
            adc_data = 48'({$urandom(), $urandom()});
            exp_q.push_back({16'h0000, adc_data});
            strobe_frame();
        end
        drain_and_compare("random");
    endtask

    task automatic test_overflow();
        int model_fill;
        mode = 1'b0; enable = 1'b1; mem_wr_ready = 1'b0;
        tick();
        model_fill = 0;
        for (int n = 0; n < 17; n++) begin
            adc_data = 48'({$urandom(), $urandom()});
            if (model_fill < 16) begin
                exp_q.push_back({16'h0000, adc_data});
                model_fill++;
            end
            strobe_frame();
            checks++;
            if (burst_req !== (model_fill >= 8)) begin
                errors++;
                $display("FAIL ovf_burst_req_at%0d: got %b want %b", model_fill, burst_req, model_fill >= 8);
            end
            if (n == 15) begin
                checks++;
                if (overflow !== 1'b0) begin
                    errors++;
                    $display("FAIL ovf_early: overflow %b want 0 at 16 frames", overflow);
                end
            end
        end
        checks++;
        if (fill_level !== 5'd16 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_state: fill %0d ov %b, want 16 and 1", fill_level, overflow);
        end
        drain_and_compare("ovf");
    endtask

    task automatic test_back_to_back();
        mode = 1'b0; enable = 1'b1; mem_wr_ready = 1'b0;
        tick();
        for (int n = 0; n < 16; n++) begin
            adc_data = 48'({$urandom(), $urandom()});
            exp_q.push_back({16'h0000, adc_data});
            strobe_frame();
        end
        adc_data = 48'({$urandom(), $urandom()});
        exp_q.push_back({16'h0000, adc_data});
        lrclk = 1'b1;
        repeat (3) tick();
        mem_wr_ready = 1'b1;
        tick();
        mem_wr_ready = 1'b0;
        lrclk = 1'b0;
        checks++;
        if (fill_level !== 5'd16 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL b2b_full_pushpop: fill %0d ov %b, want 16 and 0", fill_level, overflow);
        end
        repeat (3) tick();
        drain_and_compare("b2b");
    endtask

    task automatic test_drain();
        int k;
        mode = 1'b0; enable = 1'b1; mem_wr_ready = 1'b0;
        tick();
        for (int n = 0; n < 3; n++) begin
            adc_data = 48'({$urandom(), $urandom()});
            exp_q.push_back({16'h0000, adc_data});
            strobe_frame();
        end
        enable = 1'b0;
        tick();
        checks++;
        if (burst_req !== 1'b1 || mem_wr_valid !== 1'b1 || fill_level !== 5'd3) begin
            errors++;
            $display("FAIL drain_entry: br %b v %b fill %0d, want 1 1 3", burst_req, mem_wr_valid, fill_level);
        end
        drain_and_compare("drain");
        checks++;
        if (burst_req !== 1'b0 || mem_wr_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_idle: br %b v %b, want 0 0", burst_req, mem_wr_valid);
        end
        strobe_frame();
        checks++;
        if (fill_level !== 5'd0) begin
            errors++;
            $display("FAIL idle_ignores_strobe: fill %0d want 0", fill_level);
        end
    endtask

    task automatic test_play(input int n_words);
        mode = 1'b1; enable = 1'b1; adc_data = '0;
        play_w.delete();
        for (int i = 0; i < n_words; i++) play_w.push_back({$urandom(), $urandom()});
        tick();
        checks++;
        if (mem_rd_ready !== 1'b1 || burst_req !== 1'b1 || dac_data !== '0) begin
            errors++;
            $display("FAIL play_prime: rr %b br %b dac %h, want 1 1 0", mem_rd_ready, burst_req, dac_data);
        end
        feed_words(n_words);
        tick();
        checks++;
        if (fill_level !== 5'(n_words) || burst_req !== (n_words <= 8) || mem_rd_ready !== (n_words < 16)) begin
            errors++;
            $display("FAIL play_filled: fill %0d br %b rr %b, want %0d %b %b",
                     fill_level, burst_req, mem_rd_ready, n_words, n_words <= 8, n_words < 16);
        end
        for (int i = 0; i < n_words; i++) begin
            strobe_frame();
            checks++;
            if (dac_data !== play_w[i][47:0] || fill_level !== 5'(n_words - 1 - i) || underflow !== 1'b0) begin
                errors++;
                $display("FAIL play_frame%0d: dac %h fill %0d un %b, want %h %0d 0",
                         i, dac_data, fill_level, underflow, play_w[i][47:0], n_words - 1 - i);
            end
        end
        strobe_frame();
        checks++;
        if (dac_data !== '0 || underflow !== 1'b1) begin
            errors++;
            $display("FAIL play_starve: dac %h un %b, want 0 1", dac_data, underflow);
        end
        enable = 1'b0;
        tick();
        checks++;
        if (mem_rd_ready !== 1'b0 || fill_level !== 5'd0 || dac_data !== '0) begin
            errors++;
            $display("FAIL play_stop: rr %b fill %0d dac %h, want 0 0 0", mem_rd_ready, fill_level, dac_data);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        mode = 1'b0; enable = 1'b1; mem_wr_ready = 1'b0;
        tick();
        for (int n = 0; n < 4; n++) begin
            adc_data = 48'({$urandom(), $urandom()});
            strobe_frame();
        end
        lrclk = 1'b1;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        checks++;
        if (fill_level !== 5'd0 || mem_wr_valid !== 1'b0 || burst_req !== 1'b0 || mem_wr_data !== '0) begin
            errors++;
            $display("FAIL rst_mid_record: fill %0d v %b br %b data %h, want all 0",
                     fill_level, mem_wr_valid, burst_req, mem_wr_data);
        end
        lrclk = 1'b0; enable = 1'b0; rst = 1'b0;
        repeat (3) tick();
        mode = 1'b1; enable = 1'b1;
        play_w.delete();
        for (int i = 0; i < 3; i++) play_w.push_back({$urandom(), $urandom()});
        tick();
        feed_words(3);
        mem_rd_valid = 1'b1; mem_rd_data = {$urandom(), $urandom()};
        rst = 1'b1;
        tick();
        checks++;
        if (fill_level !== 5'd0 || mem_rd_ready !== 1'b0 || burst_req !== 1'b0 || dac_data !== '0) begin
            errors++;
            $display("FAIL rst_mid_play: fill %0d rr %b br %b dac %h, want all 0",
                     fill_level, mem_rd_ready, burst_req, dac_data);
        end
        mem_rd_valid = 1'b0; enable = 1'b0; rst = 1'b0;
        tick();
    endtask

`ifdef OVERDUB_EN
    function automatic logic [23:0] ref_sat(input logic [23:0] a, input logic [23:0] b);
        int s;
        s = int'(signed'(a)) + int'(signed'(b));
        if (s > 8388607) s = 8388607;
        if (s < -8388608) s = -8388608;
        return s[23:0];
    endfunction

    task automatic test_overdub();
        logic [23:0] mem_ch0 [2];
        logic [23:0] adc_ch0 [2];
        logic [23:0] ch1;
        mem_ch0[0] = 24'h7FFFF0; adc_ch0[0] = 24'h000020;
        mem_ch0[1] = 24'h800010; adc_ch0[1] = 24'hFFFF00;
        mode = 1'b1; enable = 1'b1;
        play_w.delete();
        for (int i = 0; i < 8; i++) play_w.push_back({16'h0, 24'($urandom()), (i < 2) ? mem_ch0[i] : 24'($urandom())});
        tick();
        feed_words(8);
        tick();
        for (int i = 0; i < 2; i++) begin
            ch1 = 24'($urandom());
            adc_data = {ch1, adc_ch0[i]};
            strobe_frame();
            checks++;
            if (dac_data !== {ref_sat(play_w[i][47:24], ch1), ref_sat(mem_ch0[i], adc_ch0[i])}) begin
                errors++;
                $display("FAIL overdub%0d: dac %h want %h", i, dac_data,
                         {ref_sat(play_w[i][47:24], ch1), ref_sat(mem_ch0[i], adc_ch0[i])});
            end
        end
        enable = 1'b0;
        adc_data = '0;
        repeat (2) tick();
    endtask
`endif

    initial begin
        test_reset();
        test_record_stream();
        test_record_random();
        test_overflow();
        test_back_to_back();
        test_drain();
        test_play(8);
        test_play(16);
        test_reset_mid();
`ifdef OVERDUB_EN
        test_overdub();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
